// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and the
// fetch-stage state encoding used by instruction_fetch.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'b000000;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_SW     = 6'b101011;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Field bit positions within a 32-bit MIPS instruction word
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: loads RESET_PC on reset, takes a branch
// redirect with highest priority, otherwise steps by 4 when told to advance.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next PC: redirect beats sequential advance; wraps naturally at 2^XLEN
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (advance) begin
      pc_d = pc_plus4;
    end
  end

  // PC register with asynchronous reset to the boot vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register. Fetches one word per request,
// presents it with decoded fields, honours decode stall and branch flush.
// Optional macro IFETCH_SKID_EN adds a one-entry skid buffer so a word that
// returns while IF/ID is blocked is kept instead of being refetched.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc4,
  output logic [5:0]      if_opcode,
  output logic [4:0]      if_rs,
  output logic [4:0]      if_rt,
  output logic [4:0]      if_rd,
  output logic [5:0]      if_funct,
  output logic [15:0]     if_imm
);

  fetch_state_e    state_q, state_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc4_q, if_pc4_d;
  logic            pc_advance;
  logic            pc_redirect;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            load_ok;

`ifdef IFETCH_SKID_EN
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
`endif

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .advance  (pc_advance),
    .redirect (pc_redirect),
    .target   (branch_target),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // IF/ID can take a new word if it is empty or being consumed this cycle
  assign load_ok   = !if_valid_q || !stall;
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc;

  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc4    = if_pc4_q;
  assign if_opcode = if_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign if_rs     = if_instr_q[RS_MSB:RS_LSB];
  assign if_rt     = if_instr_q[RT_MSB:RT_LSB];
  assign if_rd     = if_instr_q[RD_MSB:RD_LSB];
  assign if_funct  = if_instr_q[FUNCT_MSB:FUNCT_LSB];
  assign if_imm    = if_instr_q[IMM_MSB:IMM_LSB];

  // Fetch sequencing and IF/ID update; a taken branch overrides everything
  always_comb begin
    state_d     = state_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc4_d    = if_pc4_q;
    pc_advance  = 1'b0;
    pc_redirect = 1'b0;
`ifdef IFETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
`endif
    if (branch_taken) begin
      if_valid_d  = 1'b0;
      if_instr_d  = NOP_INSTR;
      pc_redirect = 1'b1;
      state_d     = S_REQ;
`ifdef IFETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          if (!stall) if_valid_d = 1'b0;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_valid) begin
            if (load_ok) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc4_d   = pc_plus4;
              pc_advance = 1'b1;
            end else begin
`ifdef IFETCH_SKID_EN
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              pc_advance   = 1'b1;
`endif
              state_d = S_HOLD;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b0;
`ifdef IFETCH_SKID_EN
            if (skid_valid_q) begin
              if_valid_d = 1'b1;
              if_instr_d = skid_instr_q;
              if_pc4_d   = skid_pc4_q;
            end
            skid_valid_d = 1'b0;
`endif
            state_d = S_REQ;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // State, IF/ID and skid registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc4_q   <= '0;
`ifdef IFETCH_SKID_EN
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
`ifdef IFETCH_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
`endif
    end
  end

endmodule
